// File: rtl/vlan_table_ctrl_pkg.sv
// vlan_table_ctrl_pkg: shared types and constants for the RX VLAN table controller
package vlan_table_ctrl_pkg;
  localparam int MAX_VLAN_NETS = 16;
  localparam int VLAN_ADDR_W = $clog2(MAX_VLAN_NETS);
  localparam logic [11:0] VLAN_EMPTY_VID = 12'hFFF;
  typedef enum logic [1:0] {
    VLAN_ADD   = 2'd0,
    VLAN_DEL   = 2'd1,
    VLAN_CLEAR = 2'd2,
    VLAN_RSVD  = 2'd3
  } vlan_cmd_op_t;
  typedef enum logic [2:0] {
    RSP_OK       = 3'd0,
    RSP_DUP      = 3'd1,
    RSP_FULL     = 3'd2,
    RSP_NOTFOUND = 3'd3,
    RSP_BADVID   = 3'd4,
    RSP_BADCMD   = 3'd5
  } vlan_rsp_t;
  typedef enum logic [2:0] {
    ST_INIT, ST_IDLE, ST_SCAN, ST_CLR, ST_WRITE, ST_RESP
  } vlan_state_t;
  typedef struct packed {
    logic                   wr_val;
    logic [VLAN_ADDR_W-1:0] addr;
    logic [11:0]            vid;
  } vlan_setup_t;
endpackage

// File: rtl/vlan_table_ctrl.sv
// vlan_table_ctrl: ADD/DEL/CLEAR command engine with a flop shadow of the filter VLAN RAM
module vlan_table_ctrl
  import vlan_table_ctrl_pkg::*;
#(
  parameter int          pNETS      = MAX_VLAN_NETS,
  parameter logic [11:0] pEMPTY_VID = VLAN_EMPTY_VID
) (
  input  logic                       clk,
  input  logic                       main_rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  vlan_cmd_op_t               cmd_op,
  input  logic [11:0]                cmd_vid,
  output logic                       rsp_valid,
  output vlan_rsp_t                  rsp_status,
  output logic [$clog2(pNETS)-1:0]   rsp_index,
  output logic [$clog2(pNETS+1)-1:0] entry_cnt,
  output vlan_setup_t                vlan_setup
);
  localparam int IW = $clog2(pNETS);
  localparam int CW = $clog2(pNETS+1);
  localparam logic [IW-1:0] LAST = IW'(pNETS-1);
  vlan_state_t state_q, state_d;
  vlan_cmd_op_t op_q, op_d;
  logic [IW-1:0] idx_q, idx_d, tgt_q, tgt_d, rsp_index_q, rsp_index_d;
  logic [11:0] vid_q, vid_d;
  logic dup_q, dup_d, found_q, found_d, rsp_valid_q, rsp_valid_d, hit;
  logic [11:0] shadow_q [pNETS];
  logic [11:0] shadow_d [pNETS];
  logic [pNETS-1:0] valid_q, valid_d;
  logic [CW-1:0] cnt_q, cnt_d;
  vlan_rsp_t rsp_status_q, rsp_status_d;
  vlan_setup_t setup_q, setup_d;
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    idx_d = idx_q;
    tgt_d = tgt_q;
    vid_d = vid_q;
    dup_d = dup_q;
    found_d = found_q;
    shadow_d = shadow_q;
    valid_d = valid_q;
    cnt_d = cnt_q;
    rsp_valid_d = 1'b0;
    rsp_status_d = RSP_OK;
    rsp_index_d = '0;
    setup_d = '0;
    hit = valid_q[idx_q] && shadow_q[idx_q] == vid_q;
    case (state_q)
      ST_INIT:
        // leave only once the last sweep write is visible on the port
        if (setup_q.wr_val && setup_q.addr == VLAN_ADDR_W'(LAST)) state_d = ST_IDLE;
        else begin
          setup_d = '{wr_val: 1'b1, addr: VLAN_ADDR_W'(idx_q), vid: pEMPTY_VID};
          idx_d = idx_q == LAST ? '0 : idx_q + IW'(1);
        end
      ST_IDLE:
        if (cmd_valid) begin
          vid_d = cmd_vid;
          op_d = cmd_op;
          idx_d = '0;
          tgt_d = '0;
          dup_d = 1'b0;
          found_d = 1'b0;
          if (cmd_op == VLAN_CLEAR) begin
            state_d = ST_CLR;
            setup_d = '{wr_val: 1'b1, addr: '0, vid: pEMPTY_VID};
            idx_d = IW'(1);
          end else if (cmd_op == VLAN_RSVD || cmd_vid == pEMPTY_VID) begin
            state_d = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_status_d = cmd_op == VLAN_RSVD ? RSP_BADCMD : RSP_BADVID;
          end else state_d = ST_SCAN;
        end
      ST_SCAN: begin
        if (op_q == VLAN_ADD) begin
          dup_d = dup_q | hit;
          if (!valid_q[idx_q] && !found_q) begin
            found_d = 1'b1;
            tgt_d = idx_q;
          end
        end else if (hit && !found_q) begin
          found_d = 1'b1;
          tgt_d = idx_q;
        end
        idx_d = idx_q == LAST ? '0 : idx_q + IW'(1);
        if (idx_q == LAST) begin
          if (dup_d || !found_d) begin
            state_d = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_status_d = dup_d ? RSP_DUP : op_q == VLAN_ADD ? RSP_FULL : RSP_NOTFOUND;
          end else begin
            state_d = ST_WRITE;
            setup_d = '{wr_val: 1'b1, addr: VLAN_ADDR_W'(tgt_d),
                        vid: op_q == VLAN_ADD ? vid_q : pEMPTY_VID};
          end
        end
      end
      ST_CLR: begin
        setup_d = '{wr_val: 1'b1, addr: VLAN_ADDR_W'(idx_q), vid: pEMPTY_VID};
        idx_d = idx_q == LAST ? '0 : idx_q + IW'(1);
        if (idx_q == LAST) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        state_d = ST_RESP;
        rsp_valid_d = 1'b1;
        rsp_index_d = op_q == VLAN_CLEAR ? '0 : tgt_q;
        cnt_d = op_q == VLAN_CLEAR ? '0 :
                op_q == VLAN_ADD ? (cnt_q == CW'(pNETS) ? cnt_q : cnt_q + CW'(1)) :
                (cnt_q == '0 ? cnt_q : cnt_q - CW'(1));
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_INIT;
    endcase
    // the shadow tracks every RAM write, so a slot is valid iff it holds a real VID
    if (setup_d.wr_val) begin
      shadow_d[setup_d.addr] = setup_d.vid;
      valid_d[setup_d.addr] = setup_d.vid != pEMPTY_VID;
    end
  end
  always_ff @(posedge clk or posedge main_rst) begin
    if (main_rst) begin
      state_q <= ST_INIT;
      op_q <= VLAN_ADD;
      idx_q <= '0;
      tgt_q <= '0;
      vid_q <= '0;
      dup_q <= 1'b0;
      found_q <= 1'b0;
      shadow_q <= '{default: pEMPTY_VID};
      valid_q <= '0;
      cnt_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_status_q <= RSP_OK;
      rsp_index_q <= '0;
      setup_q <= '0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      idx_q <= idx_d;
      tgt_q <= tgt_d;
      vid_q <= vid_d;
      dup_q <= dup_d;
      found_q <= found_d;
      shadow_q <= shadow_d;
      valid_q <= valid_d;
      cnt_q <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_status_q <= rsp_status_d;
      rsp_index_q <= rsp_index_d;
      setup_q <= setup_d;
    end
  end
  always_ff @(posedge clk) begin
    if (!main_rst && state_q == ST_WRITE && op_q != VLAN_CLEAR)
      assert (!(op_q == VLAN_ADD && cnt_q == CW'(pNETS)) && !(op_q == VLAN_DEL && cnt_q == '0))
        else $error("vlan_table_ctrl: entry_cnt saturated on update");
  end
  assign cmd_ready = state_q == ST_IDLE;
  assign rsp_valid = rsp_valid_q;
  assign rsp_status = rsp_status_q;
  assign rsp_index = rsp_index_q;
  assign entry_cnt = cnt_q;
  assign vlan_setup = setup_q;
endmodule
